// File: rtl/max_box_sum_param.sv
// Windowed-maximum engine: streams a WIN x WIN OM score map in raster order and
// reports the largest BOX x BOX box sum, its top-left position and a threshold hit.
module max_box_sum_param #(
   parameter int DW  = 32,
   parameter int WIN = 19,
   parameter int BOX = 5,
   parameter int AW  = 13,
   localparam int SW  = DW + $clog2(BOX * BOX),
   localparam int RCW = $clog2(WIN)
) (
   input  logic           iClk,
   input  logic           iReset_n,
   input  logic           iStart,
   input  logic           iAbort,
   input  logic [AW-1:0]  iBase,
   input  logic [SW-1:0]  iThresh,
   output logic           oRd,
   output logic [AW-1:0]  oAddr,
   input  logic [DW-1:0]  iData,
   output logic           oBusy,
   output logic           oValid,
   input  logic           iReady,
   output logic [SW-1:0]  oMax,
   output logic [RCW-1:0] oRow,
   output logic [RCW-1:0] oCol,
   output logic           oHit,
   output logic [1:0]     oState
);
   localparam int NJ  = WIN - BOX + 1;
   localparam int JW  = (NJ > 1) ? $clog2(NJ) : 1;
   localparam int SLW = (BOX > 1) ? $clog2(BOX) : 1;
   localparam logic [RCW-1:0] LAST_RC   = RCW'(WIN - 1);
   localparam logic [RCW-1:0] BOX_M1    = RCW'(BOX - 1);
   localparam logic [SLW-1:0] SLOT_LAST = SLW'(BOX - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     drain_q, drain_d;
   logic [RCW-1:0] row_q, col_q;
   logic [AW-1:0]  addr_q;
   logic [SW-1:0]  thresh_q;
   logic           last_rd, start_acc, load_res, flush;

   // Stage 1: sample returning from OM, tagged with its map coordinates
   logic           v1_q;
   logic [RCW-1:0] r1_q, c1_q;
   logic [DW-1:0]  hist_q [BOX];
   logic [SW-1:0]  hsum_q;
   logic [SW-1:0]  hbuf_q [BOX][NJ];
   logic [SW-1:0]  colacc_q [NJ];
   logic [SLW-1:0] slot_q;

   // Stage 2: box sum; stage 3: running maximum
   logic           bs_v_q;
   logic [SW-1:0]  bs_q;
   logic [RCW-1:0] bs_r_q, bs_c_q;
   logic           have_q;
   logic [SW-1:0]  max_q;
   logic [RCW-1:0] max_r_q, max_c_q;

   logic           valid_q, res_hit_q;
   logic [SW-1:0]  res_max_q;
   logic [RCW-1:0] res_row_q, res_col_q;

   logic [31:0]    c1_w, r1_w;
   logic           col_ok, row_ok;
   logic [JW-1:0]  j1;
   logic [SW-1:0]  hs_drop, hsum_d, col_base, col_drop, box_d;

   assign last_rd   = (row_q == LAST_RC) && (col_q == LAST_RC);
   assign start_acc = (state_q == S_IDLE) && iStart && !iAbort;
   assign flush     = iAbort && ((state_q == S_READ) || (state_q == S_DRAIN));
   assign load_res  = (state_q == S_DRAIN) && (drain_q == 2'd2) && !iAbort;

   assign oRd    = (state_q == S_READ);
   assign oAddr  = oRd ? addr_q : '0;
   assign oBusy  = (state_q != S_IDLE);
   assign oState = state_q;
   assign oValid = valid_q;
   assign oMax   = res_max_q;
   assign oRow   = res_row_q;
   assign oCol   = res_col_q;
   assign oHit   = res_hit_q;

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_q <= S_IDLE;
         drain_q <= 2'd0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Result handshake: oValid rises in DONE with a stable payload and stays until
   // iReady (or iAbort) is sampled high; the result transfers on that edge.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE: begin
            if (iStart && !iAbort) state_d = S_READ;
         end
         S_READ: begin
            if (iAbort) begin
               state_d = S_IDLE;
            end else if (last_rd) begin
               state_d = S_DRAIN;
               drain_d = 2'd0;
            end
         end
         S_DRAIN: begin
            if (iAbort)                  state_d = S_IDLE;
            else if (drain_q == 2'd2)    state_d = S_DONE;
            else                         drain_d = drain_q + 2'd1;
         end
         S_DONE: begin
            if (iReady || iAbort) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         row_q    <= '0;
         col_q    <= '0;
         addr_q   <= '0;
         thresh_q <= '0;
      end else if (start_acc) begin
         row_q    <= '0;
         col_q    <= '0;
         addr_q   <= iBase;
         thresh_q <= iThresh;
      end else if (state_q == S_READ) begin
         addr_q <= addr_q + AW'(1);
         if (col_q == LAST_RC) begin
            col_q <= '0;
            row_q <= row_q + RCW'(1);
         end else begin
            col_q <= col_q + RCW'(1);
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         v1_q <= 1'b0;
         r1_q <= '0;
         c1_q <= '0;
      end else begin
         v1_q <= (state_q == S_READ) && !iAbort;
         r1_q <= row_q;
         c1_q <= col_q;
      end
   end

   // Horizontal sum drops the sample BOX columns back; the column accumulator drops
   // the horizontal sum BOX rows back, held in the line-buffer slot being reused.
   always_comb begin
      c1_w     = 32'(c1_q);
      r1_w     = 32'(r1_q);
      col_ok   = (c1_w >= 32'(BOX - 1));
      row_ok   = (r1_w >= 32'(BOX - 1));
      j1       = col_ok ? JW'(c1_q - BOX_M1) : '0;
      hs_drop  = (c1_w >= 32'(BOX)) ? SW'(hist_q[BOX-1]) : '0;
      hsum_d   = ((c1_q == '0) ? '0 : hsum_q) + SW'(iData) - hs_drop;
      col_base = (r1_q == '0) ? '0 : colacc_q[j1];
      col_drop = (r1_w >= 32'(BOX)) ? hbuf_q[slot_q][j1] : '0;
      box_d    = col_base + hsum_d - col_drop;
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         hsum_q <= '0;
         slot_q <= '0;
         for (int k = 0; k < BOX; k++) begin
            hist_q[k] <= '0;
            for (int j = 0; j < NJ; j++) hbuf_q[k][j] <= '0;
         end
         for (int j = 0; j < NJ; j++) colacc_q[j] <= '0;
      end else begin
         if (v1_q) begin
            hist_q[0] <= iData;
            for (int k = 1; k < BOX; k++) hist_q[k] <= hist_q[k-1];
            hsum_q <= hsum_d;
            if (col_ok) begin
               hbuf_q[slot_q][j1] <= hsum_d;
               colacc_q[j1]       <= box_d;
            end
            if (c1_q == LAST_RC) slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + SLW'(1);
         end
         if (start_acc) slot_q <= '0;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         bs_v_q    <= 1'b0;
         bs_q      <= '0;
         bs_r_q    <= '0;
         bs_c_q    <= '0;
         have_q    <= 1'b0;
         max_q     <= '0;
         max_r_q   <= '0;
         max_c_q   <= '0;
         valid_q   <= 1'b0;
         res_max_q <= '0;
         res_row_q <= '0;
         res_col_q <= '0;
         res_hit_q <= 1'b0;
      end else begin
         bs_v_q <= v1_q && col_ok && row_ok && !flush;
         bs_q   <= box_d;
         bs_r_q <= r1_q - BOX_M1;
         bs_c_q <= RCW'(j1);
         // Strictly-greater update keeps the earliest raster position on ties
         if (start_acc) begin
            have_q <= 1'b0;
         end else if (bs_v_q && (!have_q || (bs_q > max_q))) begin
            have_q  <= 1'b1;
            max_q   <= bs_q;
            max_r_q <= bs_r_q;
            max_c_q <= bs_c_q;
         end
         if (load_res) begin
            valid_q   <= 1'b1;
            res_max_q <= max_q;
            res_row_q <= max_r_q;
            res_col_q <= max_c_q;
            res_hit_q <= (max_q >= thresh_q);
         end else if ((state_q == S_DONE) && (iReady || iAbort)) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: doc/max_box_sum_param.md
Name: max_box_sum_param

Overview:
- Parametrised windowed-maximum engine for the face-detection output-map (OM) path.
- Streams a WIN x WIN score map from OM memory in raster order and forms every BOX x BOX box sum.
- Reports the largest box sum, its top-left position, and a threshold hit flag through a valid/ready result port.
- Replaces the fixed 19x19 / 5x5 max-value datapath; adds runtime base address, runtime threshold, abort, and output back-pressure.

Parameters:
- DW, 32, unsigned OM sample width.
- WIN, 19, map side length; legal range 2..64.
- BOX, 5, box side length; 1 <= BOX <= WIN.
- AW, 13, OM address width.
- Derived SW = DW + clog2(BOX*BOX): box-sum width.
- Derived RCW = clog2(WIN): row and column width.

Ports:
- iClk, in, 1: clock.
- iReset_n, in, 1: reset.
- iStart, in, 1: start request; accepted only in IDLE.
- iAbort, in, 1: cancel the current scan.
- iBase, in, AW: OM address of map element (0,0); sampled when iStart is accepted.
- iThresh, in, SW: hit threshold; sampled when iStart is accepted.
- oRd, out, 1: OM read strobe.
- oAddr, out, AW: OM read address.
- iData, in, DW: OM read data; valid exactly 1 cycle after the oRd cycle.
- oBusy, out, 1: high in every state except IDLE.
- oValid, out, 1: result valid.
- iReady, in, 1: result consumed.
- oMax, out, SW: maximum box sum.
- oRow, out, RCW: top-left row of the winning box.
- oCol, out, RCW: top-left column of the winning box.
- oHit, out, 1: oMax >= sampled iThresh.

Behaviour:
- Reset: iReset_n, synchronous, active-low; clock iClk. While reset is low and on the cycle after it releases, all outputs are 0, FSM is IDLE, and line buffers and max register are cleared. Reset mid-scan discards the scan with no oValid.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on iStart. Base and threshold are latched in the same edge.
  - READ issues WIN*WIN reads on consecutive cycles with oRd continuously high. The first read is the cycle after the start is accepted. oAddr = iBase + r*WIN + c, raster order, modulo 2^AW (wrap allowed).
  - READ -> DRAIN after the read of (WIN-1, WIN-1). If that read is in cycle T, oRd is low from T+1.
  - DRAIN lasts 3 cycles: data return at T+1, box-sum register at T+2, max-compare register at T+3.
  - oValid rises at T+4 in DONE. Total latency from accepted iStart at cycle S to oValid is WIN*WIN+4 cycles.
  - DONE holds oValid, oMax, oRow, oCol, oHit stable until iReady is sampled high. Then DONE -> IDLE, and oValid is low the next cycle.
  - iStart is ignored in every state except IDLE, including the cycle iReady is accepted.
- Box sum for top-left (r,c), with 0 <= r,c <= WIN-BOX: the unsigned sum of the BOX*BOX samples. Width SW, never overflows.
  - Implementation: horizontal running sum over the last BOX samples of each row, plus a column accumulator line buffer of WIN-BOX+1 entries by BOX rows.
  - Samples outside a valid box position never contribute.
- Max tracking:
  - Initialised to the first valid box sum, at position (0,0).
  - Updated only on strictly greater, so ties resolve to the earliest position in raster order of (r,c).
- oHit is computed from the final oMax and registered with oValid.
- Abort:
  - iAbort in READ or DRAIN: oRd is low next cycle, FSM -> IDLE, no oValid, pipeline flushed.
  - iAbort in DONE acts as iReady (result dropped).
  - iAbort in IDLE has no effect. iAbort wins over iStart in the same cycle.
- BOX = WIN: exactly one box; result position is (0,0).
- BOX = 1: plain maximum sample with its position.
- iData is ignored on any cycle not 1 cycle after an oRd.

Test Plan:
- All-zero 19x19 map, iBase=0, iThresh=0 -> reads at addr 0..360 on 361 consecutive cycles; oValid 365 cycles after start; oMax=0, oRow=0, oCol=0 (tie-break), oHit=1.
- Single sample 100 at (10,10), rest 0, iThresh=101 -> oMax=100, oRow=6, oCol=6, oHit=0.
- Ramp data[r][c]=r*19+c, iThresh=8000 -> oMax=8000, oRow=14, oCol=14, oHit=1; repeat with iThresh=8001 -> oHit=0.
- All samples 0xFFFFFFFF -> oMax=25*(2^32-1)=0x18_FFFF_FFE7 (37 bits), position (0,0); iBase=8100 -> oAddr wraps from 8191 to 0 without gaps.
- Handshake and abort:
  - iReady held low 10 cycles -> outputs stable throughout, single acceptance.
  - iStart pulsed while busy -> ignored.
  - iAbort at read 200 -> oRd low next cycle, no oValid, next iStart runs a clean scan.
- Param variant WIN=8, BOX=3, data[r][c]=(r==c)?7:1 -> 64 reads, oMax=27, position (0,0); reset asserted mid-READ -> all outputs 0 next cycle.
